// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and baud-timing helpers
// Holds the receiver FSM encoding, a bit-width helper and the per-bit
// clock count derivation shared with the transmit-side clock generator.
package uart_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

    // number of bits needed to represent v (at least 1)
    function automatic int bit_width(input int v);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++)
            if ((v >> i) != 0) w = i + 1;
        return w;
    endfunction

    // clocks per bit minus one; integer truncation is intentional
    function automatic int bps_cnt(input int clk_freq, input int baud);
        return clk_freq / baud - 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-FF synchronizer plus falling-edge detector for the rx line
// Ports: clk, rst (async, active-high), rx_in (raw line),
//        rx_s (synchronized line), fall_pulse (1 when rx_s goes 1 -> 0).
// All flops reset to 1 so an idle-high line never fakes an edge out of reset.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    output logic rx_s,
    output logic fall_pulse
);

    logic s1, s2, s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= rx_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rx_s       = s2;
    assign fall_pulse = s3 & ~s2;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first UART receiver, self-timed from the system clock
// Ports: clk, rst (async, active-high), rx_in (raw serial line),
//        rx_data (last good byte), rx_done (1-cycle good-frame pulse),
//        frame_err (1-cycle bad-stop pulse), rx_busy (FSM not idle).
// The start bit is re-centred at HALF, after which every bit is sampled
// BPS_CNT+1 clocks apart, i.e. in the middle of each bit cell.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQUENCE = 50_000_000,
    parameter int BAUD_RATE     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int BPS_CNT = bps_cnt(CLK_FREQUENCE, BAUD_RATE);
    localparam int HALF    = BPS_CNT / 2;
    localparam int CNT_WD  = bit_width(BPS_CNT);
    localparam logic [CNT_WD-1:0] BPS_C  = CNT_WD'(BPS_CNT);
    localparam logic [CNT_WD-1:0] HALF_C = CNT_WD'(HALF);

    rx_state_t         st, nxt;
    logic [CNT_WD-1:0] cnt;
    logic [2:0]        idx;
    logic [7:0]        shreg;
    logic              rx_s, fall;
    logic              bit_end, half_hit, shift_en, done_d, err_d;

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .rx_s      (rx_s),
        .fall_pulse(fall)
    );

    assign bit_end  = cnt == BPS_C;
    assign half_hit = cnt == HALF_C;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= nxt;
    end

    always_comb begin
        nxt = st;
        case (st)
            IDLE:    nxt = fall ? START : IDLE;
            START:   nxt = half_hit ? (rx_s ? IDLE : DATA) : START;
            DATA:    nxt = (bit_end && idx == 3'd7) ? STOP : DATA;
            STOP:    nxt = bit_end ? IDLE : STOP;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        shift_en = st == DATA && bit_end;
        done_d   = st == STOP && bit_end && rx_s;
        err_d    = st == STOP && bit_end && !rx_s;
        rx_busy  = st != IDLE;
    end

    // idx wraps 7 -> 0 on the last data sample, leaving it cleared for STOP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= 3'd0;
            shreg     <= 8'h00;
            rx_data   <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cnt       <= (st == IDLE) ? '0
                       : (st == START) ? (half_hit ? '0 : cnt + 1'b1)
                       : (bit_end ? '0 : cnt + 1'b1);
            idx       <= shift_en ? idx + 3'd1 : idx;
            shreg     <= shift_en ? {rx_s, shreg[7:1]} : shreg;
            rx_data   <= done_d ? shreg : rx_data;
            rx_done   <= done_d;
            frame_err <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx with a frame-level reference model
module tb_uart_rx;

    localparam int BIT = 16;
    localparam int LAT = 155;

    typedef struct {
        logic       err;
        logic [7:0] data;
        int         cyc;
        logic       busy;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done, frame_err, rx_busy;

    ev_t        got_q[$];
    ev_t        exp_q[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    int         bad_pulse = 0;
    logic [7:0] last_good = 8'h00;
    logic       pd = 1'b0, pe = 1'b0;

    uart_rx #(.CLK_FREQUENCE(1_600_000), .BAUD_RATE(100_000)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_in    (rx_in),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .frame_err(frame_err),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_done || frame_err) got_q.push_back(ev_t'{frame_err, rx_data, cyc, rx_busy});
        if ((rx_done && frame_err) || (rx_done && pd) || (frame_err && pe)) bad_pulse++;
        pd = rx_done;
        pe = frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx_in = v;
        repeat (n) @(negedge clk);
    endtask

    // model: a frame yields one event LAT clocks after its start edge is driven
    task automatic send(input logic [7:0] b, input logic stop);
        int n0;
        n0 = cyc;
        exp_q.push_back(stop ? ev_t'{1'b0, b, n0 + LAT, 1'b0}
                             : ev_t'{1'b1, last_good, n0 + LAT, 1'b0});
        if (stop) last_good = b;
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(b[i], BIT);
        hold(stop, BIT);
    endtask

    task automatic drain(input string tag, input int idle);
        ev_t g, e;
        repeat (idle) @(negedge clk);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() != 0 && exp_q.size() != 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk({tag, "_kind"}, {31'd0, g.err}, {31'd0, e.err});
            chk({tag, "_data"}, {24'd0, g.data}, {24'd0, e.data});
            chk({tag, "_busy"}, {31'd0, g.busy}, {31'd0, e.busy});
            chk({tag, "_time"}, (g.cyc >= e.cyc - 2 && g.cyc <= e.cyc + 2) ? e.cyc : g.cyc, e.cyc);
        end
        got_q.delete();
        exp_q.delete();
        chk({tag, "_pulse"}, bad_pulse, 0);
    endtask

    initial begin
        int n0;
        logic [7:0] b;
        logic stop;
        repeat (3) @(negedge clk);
        chk("rst_data", {24'd0, rx_data}, 32'h00);
        chk("rst_done", {31'd0, rx_done}, 32'h0);
        chk("rst_err", {31'd0, frame_err}, 32'h0);
        chk("rst_busy", {31'd0, rx_busy}, 32'h0);
        rst = 1'b0;
        hold(1'b1, 20);

        send(8'hA5, 1'b1);
        drain("single", 20);
        chk("single_rx_data", {24'd0, rx_data}, 32'hA5);

        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h5A, 1'b1);
        drain("b2b", 20);

        send(8'h3C, 1'b0);
        hold(1'b1, BIT);
        send(8'h81, 1'b1);
        drain("stop_err", 20);

        n0 = cyc;
        hold(1'b0, 4);
        chk("glitch_busy_hi", {31'd0, rx_busy}, 32'h1);
        hold(1'b1, n0 + 11 - cyc);
        chk("glitch_busy_lo", {31'd0, rx_busy}, 32'h0);
        hold(1'b1, 20);
        drain("glitch", 0);
        send(8'h42, 1'b1);
        drain("after_glitch", 20);

        b = 8'hF0;
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(b[i], BIT);
        hold(b[4], 8);
        rst = 1'b1;
        #1;
        chk("midrst_data", {24'd0, rx_data}, 32'h00);
        chk("midrst_busy", {31'd0, rx_busy}, 32'h0);
        chk("midrst_done", {31'd0, rx_done}, 32'h0);
        chk("midrst_err", {31'd0, frame_err}, 32'h0);
        @(negedge clk);
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_good = 8'h00;
        hold(1'b1, 20);
        drain("midrst", 0);
        send(8'hC3, 1'b1);
        drain("after_rst", 20);

        n0 = cyc;
        exp_q.push_back(ev_t'{1'b1, last_good, n0 + LAT, 1'b0});
        hold(1'b0, 20 * BIT);
        hold(1'b1, 2 * BIT);
        drain("break", 0);
        send(8'h7E, 1'b1);
        drain("after_break", 20);

        repeat (8) begin
            b = 8'($urandom);
            stop = $urandom_range(3) != 0;
            send(b, stop);
            hold(1'b1, stop ? $urandom_range(20) : $urandom_range(20, 4));
        end
        drain("rand", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
